// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU execute unit.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SLL     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SUB     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_SLT     = 4'b1000,
    ALU_SLTU    = 4'b1001,
    ALU_MUL     = 4'b1010,
    ALU_ILLEGAL = 4'b1111
  } alu_ctr_t;

  localparam logic [1:0] ALU_OP_LS = 2'b00;
  localparam logic [1:0] ALU_OP_BR = 2'b01;
  localparam logic [1:0] ALU_OP_R  = 2'b10;
  localparam logic [1:0] ALU_OP_I  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between register-read and the ALU execute unit.
interface alu_mc_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_operation;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;
  logic [3:0]      alu_ctr;

  modport master (
    output in_valid, alu_operation, funct7, funct3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, alu_ctr
  );

  modport slave (
    input  in_valid, alu_operation, funct7, funct3, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, alu_ctr
  );
endinterface

// File: rtl/alu_mc_decode.sv
// Combinational ALU control decoder: operation class + funct7/funct3 -> control code.
module alu_mc_decode
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0] alu_operation,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output alu_ctr_t   alu_ctr
);

  // On RV64 the I-type funct7 LSB carries shamt[5], so it takes no part in the check.
  localparam logic [6:0] F7_I_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

  logic [6:0] f7_i;

  always_comb begin
    f7_i    = funct7 & F7_I_MASK;
    alu_ctr = ALU_ILLEGAL;
    case (alu_operation)
      ALU_OP_LS: alu_ctr = ALU_ADD;
      ALU_OP_BR: alu_ctr = ALU_SUB;
      ALU_OP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: alu_ctr = ALU_ADD;
            3'b111: alu_ctr = ALU_AND;
            3'b110: alu_ctr = ALU_OR;
            3'b100: alu_ctr = ALU_XOR;
            3'b001: alu_ctr = ALU_SLL;
            3'b101: alu_ctr = ALU_SRL;
            3'b010: alu_ctr = ALU_SLT;
            3'b011: alu_ctr = ALU_SLTU;
            default: alu_ctr = ALU_ILLEGAL;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      alu_ctr = ALU_SUB;
          else if (funct3 == 3'b101) alu_ctr = ALU_SRA;
        end else if (funct7 == F7_MULDIV && funct3 == 3'b000) begin
          alu_ctr = ALU_MUL;
        end
      end
      default: begin
        case (funct3)
          3'b000: alu_ctr = ALU_ADD;
          3'b111: alu_ctr = ALU_AND;
          3'b110: alu_ctr = ALU_OR;
          3'b100: alu_ctr = ALU_XOR;
          3'b010: alu_ctr = ALU_SLT;
          3'b011: alu_ctr = ALU_SLTU;
          3'b001: if (f7_i == F7_BASE) alu_ctr = ALU_SLL;
          3'b101: begin
            if (f7_i == F7_BASE)     alu_ctr = ALU_SRL;
            else if (f7_i == F7_ALT) alu_ctr = ALU_SRA;
          end
          default: alu_ctr = ALU_ILLEGAL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_mc_unit.sv
// Handshaked ALU execute unit: registered single-cycle ops and an iterative shift-add MUL.
module alu_mc_unit
  import alu_mc_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic   clk,
  input  logic   reset,
  alu_mc_if.slave bus
);

  state_t          state, state_nxt;
  alu_ctr_t        dec_ctr, ctr_p0;
  logic [XLEN-1:0] a_p0, b_p0;
  logic [XLEN-1:0] mcand, mplier, acc;
  logic [SHAMT_W:0] cnt;
  logic [XLEN-1:0] res_p1;
  logic            zero_p1, illegal_p1;
  alu_ctr_t        ctr_p1;
  logic            accept;

  function automatic logic [XLEN-1:0] alu_calc(input alu_ctr_t ctr,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [SHAMT_W-1:0]     sh;
    sa = a;
    sb = b;
    sh = b[SHAMT_W-1:0];
    case (ctr)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_ADD:  return a + b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SUB:  return a - b;
      ALU_SRA:  return sa >>> sh;
      ALU_SLT:  return {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      default:  return '0;
    endcase
  endfunction

  alu_mc_decode #(.XLEN(XLEN)) u_decode (
    .alu_operation (bus.alu_operation),
    .funct7        (bus.funct7),
    .funct3        (bus.funct3),
    .alu_ctr       (dec_ctr)
  );

  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = res_p1;
  assign bus.zero      = zero_p1;
  assign bus.illegal   = illegal_p1;
  assign bus.alu_ctr   = ctr_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (dec_ctr == ALU_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_MUL:  if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: operands and decoded control captured on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= bus.op_a;
      b_p0   <= bus.op_b;
      ctr_p0 <= dec_ctr;
    end
  end

  // Stage p1: multiplier iterations and the held result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      res_p1     <= '0;
      zero_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
      ctr_p1     <= ALU_AND;
    end else begin
      if (accept) begin
        mcand  <= bus.op_a;
        mplier <= bus.op_b;
        acc    <= '0;
        cnt    <= (SHAMT_W+1)'(XLEN);
      end else if (state == ST_MUL && cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end

      if (state == ST_EXEC) begin
        res_p1     <= alu_calc(ctr_p0, a_p0, b_p0);
        zero_p1    <= (alu_calc(ctr_p0, a_p0, b_p0) == '0);
        illegal_p1 <= (ctr_p0 == ALU_ILLEGAL);
        ctr_p1     <= ctr_p0;
      end else if (state == ST_MUL && cnt == '0) begin
        res_p1     <= acc;
        zero_p1    <= (acc == '0);
        illegal_p1 <= 1'b0;
        ctr_p1     <= ALU_MUL;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc_unit.sv
// Directed and randomized bench for alu_mc_unit against a behavioural reference model.
module tb_alu_mc_unit;
  import alu_mc_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(XLEN)) bus ();

  alu_mc_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: instruction meaning straight from the ISA rules, arithmetic in plain operators.
  function automatic void ref_model(input logic [1:0] op, input logic [6:0] f7,
                                    input logic [2:0] f3, input logic [63:0] a,
                                    input logic [63:0] b, output logic [3:0] ctr,
                                    output logic [63:0] res);
    logic [6:0] f7i;
    f7i = {f7[6:1], 1'b0};
    ctr = ALU_ILLEGAL;
    if (op == ALU_OP_LS) ctr = ALU_ADD;
    else if (op == ALU_OP_BR) ctr = ALU_SUB;
    else if (op == ALU_OP_R) begin
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: ctr = ALU_ADD;  3'd1: ctr = ALU_SLL;  3'd2: ctr = ALU_SLT;  3'd3: ctr = ALU_SLTU;
          3'd4: ctr = ALU_XOR;  3'd5: ctr = ALU_SRL;  3'd6: ctr = ALU_OR;   default: ctr = ALU_AND;
        endcase
      end
      else if (f7 == 7'h20 && f3 == 3'd0) ctr = ALU_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) ctr = ALU_SRA;
      else if (f7 == 7'h01 && f3 == 3'd0) ctr = ALU_MUL;
    end else begin
      case (f3)
        3'd0: ctr = ALU_ADD;  3'd2: ctr = ALU_SLT;  3'd3: ctr = ALU_SLTU;
        3'd4: ctr = ALU_XOR;  3'd6: ctr = ALU_OR;   3'd7: ctr = ALU_AND;
        3'd1: ctr = (f7i == 7'h00) ? ALU_SLL : ALU_ILLEGAL;
        default: ctr = (f7i == 7'h00) ? ALU_SRL : (f7i == 7'h20) ? ALU_SRA : ALU_ILLEGAL;
      endcase
    end
    case (ctr)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = a + b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << b[5:0];
      ALU_SRL:  res = a >> b[5:0];
      ALU_SUB:  res = a - b;
      ALU_SRA:  res = $signed(a) >>> b[5:0];
      ALU_SLT:  res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      ALU_SLTU: res = (a < b) ? 64'd1 : 64'd0;
      ALU_MUL:  res = a * b;
      default:  res = 64'd0;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input int hold);
    logic [3:0]  ectr;
    logic [63:0] eres;
    int          lat;
    int          exp_lat;
    bit          busy_ok;
    ref_model(op, f7, f3, a, b, ectr, eres);
    exp_lat = (ectr == ALU_MUL) ? XLEN + 1 : 1;
    @(negedge clk);
    check({name, " in_ready idle"}, bus.in_ready, 1'b1);
    bus.in_valid      = 1'b1;
    bus.alu_operation = op;
    bus.funct7        = f7;
    bus.funct3        = f3;
    bus.op_a          = a;
    bus.op_b          = b;
    @(negedge clk);
    bus.in_valid      = 1'b0;
    bus.alu_operation = 2'($urandom);
    bus.funct7        = 7'($urandom);
    bus.funct3        = 3'($urandom);
    bus.op_a          = {$urandom, $urandom};
    bus.op_b          = {$urandom, $urandom};
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy"}, 64'(busy_ok), 64'd1);
    check({name, " result"}, bus.result, eres);
    check({name, " zero"}, bus.zero, (eres == 64'd0));
    check({name, " illegal"}, bus.illegal, (ectr == ALU_ILLEGAL));
    check({name, " alu_ctr"}, bus.alu_ctr, ectr);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({name, " held valid"}, bus.out_valid, 1'b1);
      check({name, " held result"}, bus.result, eres);
      check({name, " held alu_ctr"}, bus.alu_ctr, ectr);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " valid drop"}, bus.out_valid, 1'b0);
    check({name, " ready back"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [63:0] a, b;

    reset             = 1'b1;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.alu_operation = 2'b00;
    bus.funct7        = 7'h00;
    bus.funct3        = 3'h0;
    bus.op_a          = 64'd0;
    bus.op_b          = 64'd0;
    repeat (2) @(negedge clk);
    check("rst in_ready", bus.in_ready, 1'b1);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst result", bus.result, 64'd0);
    check("rst zero", bus.zero, 1'b0);
    check("rst illegal", bus.illegal, 1'b0);
    check("rst alu_ctr", bus.alu_ctr, 4'b0000);
    reset = 1'b0;

    run_op("r_add", ALU_OP_R, F7_BASE, 3'b000, 64'd5, 64'd3, 0);
    run_op("r_sub", ALU_OP_R, F7_ALT, 3'b000, 64'd3, 64'd3, 1);
    run_op("br_sub", ALU_OP_BR, 7'($urandom), 3'($urandom), 64'd3, 64'd3, 0);
    run_op("i_sra", ALU_OP_I, F7_ALT, 3'b101, 64'h8000_0000_0000_0000, 64'd4, 0);
    run_op("i_sltu", ALU_OP_I, 7'h7F, 3'b011, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("i_slt", ALU_OP_I, 7'h7F, 3'b010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("i_srl_sh5", ALU_OP_I, 7'h01, 3'b101, 64'hF000_0000_0000_0000, 64'd33, 0);
    run_op("i_sll_bad", ALU_OP_I, F7_ALT, 3'b001, 64'd7, 64'd1, 0);
    run_op("r_mul", ALU_OP_R, F7_MULDIV, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5);
    run_op("r_illegal", ALU_OP_R, F7_ALT, 3'b111, 64'd9, 64'd4, 2);

    // Abort a multiply mid-iteration with an asynchronous reset.
    @(negedge clk);
    bus.in_valid      = 1'b1;
    bus.alu_operation = ALU_OP_R;
    bus.funct7        = F7_MULDIV;
    bus.funct3        = 3'b000;
    bus.op_a          = 64'd12345;
    bus.op_b          = 64'd678;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort in_ready", bus.in_ready, 1'b1);
    check("abort out_valid", bus.out_valid, 1'b0);
    check("abort result", bus.result, 64'd0);
    check("abort zero", bus.zero, 1'b0);
    check("abort illegal", bus.illegal, 1'b0);
    check("abort alu_ctr", bus.alu_ctr, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort no output", bus.out_valid, 1'b0);
    run_op("post_abort_add", ALU_OP_LS, 7'h55, 3'b110, 64'd100, 64'd23, 0);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: f7 = F7_BASE;
        1: f7 = F7_ALT;
        2: f7 = F7_MULDIV;
        3: f7 = F7_ALT | 7'h01;
        default: f7 = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
      run_op("rand", op, f7, f3, a, b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc_unit.md
# alu_mc_unit

Parametrised, handshaked ALU execute unit for the RISC-V datapath. It decodes the 2-bit ALU operation class plus funct7/funct3 into an internal ALU control code and executes the operation. Single-cycle ops are registered with one-cycle latency; MUL runs as an iterative shift-add over XLEN cycles. It sits between the register-read stage and writeback/branch logic, and replaces the purely combinational ALU-control decoder for multi-cycle cores.

## Interface
Parameters:
- XLEN, 64, datapath width; legal values 32 or 64
- SHAMT_W, $clog2(XLEN), shift-amount width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  unit can accept; high only in IDLE
- alu_operation  in  2  00 load/store (ADD), 01 branch (SUB), 10 R-type, 11 I-type arithmetic
- funct7  in  7  instruction funct7 (I-type: imm[11:5])
- funct3  in  3  instruction funct3
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value or sign-extended immediate
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  unsupported funct combination for the given class
- alu_ctr  out  4  decoded control code of the held result

## Operation
- Decode, R-type (10): f7 0000000 with f3 000/111/110/100/001/101/010/011 → ADD/AND/OR/XOR/SLL/SRL/SLT/SLTU; f7 0100000 with f3 000 → SUB, f3 101 → SRA; f7 0000001 with f3 000 → MUL (low XLEN bits). All other combinations → ILLEGAL.
- Decode, I-type (11): f3 000→ADD, 111→AND, 110→OR, 100→XOR, 010→SLT, 011→SLTU; f3 001 needs f7 0000000 → SLL; f3 101 with f7 0000000 → SRL, 0100000 → SRA. For XLEN=64, f7[0] is shamt[5] and is ignored in the check. Any other combination → ILLEGAL.
- Classes 00 and 01 ignore funct7/funct3 and yield ADD and SUB respectively.
- Control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, MUL 1010, ILLEGAL 1111.
- Arithmetic: ADD/SUB/MUL wrap modulo 2^XLEN. Shift amount is op_b[SHAMT_W-1:0]. SLT is signed and SLTU unsigned; each yields 0 or 1, zero-extended.
- ILLEGAL: result=0, illegal=1, zero=1, one-cycle latency. The unit never hangs.
- FSM:
  - IDLE → EXEC on accept (in_valid && in_ready) of a single-cycle op.
  - IDLE → MUL on accept of a MUL op.
  - EXEC → DONE after one cycle.
  - MUL → DONE when the counter reaches 0.
  - DONE → IDLE on out_ready.
- MUL is shift-add: the multiplicand is shifted left and the multiplier shifted right each cycle for XLEN iterations.

## Timing
- Reset (asynchronous, any state): FSM=IDLE; in_ready=1; out_valid=0; result=0; zero=0; illegal=0; alu_ctr=0000; MUL counter and accumulators cleared. A reset during MUL aborts it and produces no output.
- Operands and decode are captured at the accept edge N. Later changes on the inputs have no effect.
- Single-cycle ops and ILLEGAL: out_valid=1 after edge N+1.
- MUL: out_valid=1 after edge N+XLEN+1 (XLEN iteration cycles, then a registering cycle).
- result, zero, illegal and alu_ctr change only on the cycle out_valid rises. They stay stable while out_valid && !out_ready.
- Transfer completes on the edge where out_valid && out_ready. out_valid falls and in_ready rises after that edge. A new accept is possible one cycle later, so the maximum throughput is one single-cycle op every 3 cycles.
- in_valid asserted while in_ready=0 is ignored; the source must hold its request.

## Structure
- Package alu_mc_pkg holds: the alu_ctr_t 4-bit typedef with the named codes above, the ALU_OP_* 2-bit class constants, the funct7 constants F7_BASE/F7_ALT/F7_MULDIV, and the FSM state typedef.
- Combinational sub-module alu_mc_decode: (alu_operation, funct7, funct3) → alu_ctr_t. It is verified standalone against the full input space.
- The top level contains the FSM, operand registers, the single-cycle datapath, and the iterative multiplier.

## Test plan
- R-type ADD, XLEN=64: a=5, b=3, f7=0000000, f3=000 → result=8, alu_ctr=0010, out_valid one cycle after accept.
- R-type SUB: a=3, b=3, f7=0100000 → result=0, zero=1, code 0110. Class 01 with arbitrary f7/f3 gives the same result.
- I-type SRA: a=0x8000_0000_0000_0000, b=4, f3=101, f7=0100000 → result=0xF800_0000_0000_0000. SLTU with a=1, b=-1 → 1; SLT with the same operands → 0.
- MUL: a=0xFFFF_FFFF_FFFF_FFFF, b=3 → result=0xFFFF_FFFF_FFFF_FFFD, out_valid exactly XLEN+1 cycles after accept, in_ready=0 throughout. Hold out_ready=0 for 5 cycles → result stable.
- Illegal: class 10, f7=0100000, f3=111 → illegal=1, result=0, alu_ctr=1111, latency 1.
- Assert reset at MUL iteration 10 → all outputs at reset values immediately. The next ADD completes normally with no stale MUL result.
